// File: rtl/mdu_ctrl_if.sv
// Purpose: decoder/hazard-side bundle for the multiply/divide unit (request, operands, HI/LO, stall).
// Latency: none, wires only.
// Backpressure: busy/md_stall flow back to the issuing side; the unit never accepts while busy.
interface mdu_ctrl_if;
    logic        start;
    logic [2:0]  md_op;
    logic        cancel;
    logic [31:0] a;
    logic [31:0] b;
    logic        id_md_use;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    // Pipeline side: issues operations and watches busy/stall/HI/LO
    modport master (
        output start, md_op, cancel, a, b, id_md_use,
        input  busy, md_stall, hi, lo
    );

    // Unit side
    modport slave (
        input  start, md_op, cancel, a, b, id_md_use,
        output busy, md_stall, hi, lo
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Purpose: sequenced mult/multu/div/divu unit owning HI/LO, plus single-cycle mthi/mtlo.
// Latency: MULT_CYCLES or DIV_CYCLES edges from accept to HI/LO update; mthi/mtlo take one edge.
// Backpressure: busy while running; md_stall holds any md-class instruction in D during start/busy.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  md
);
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, RUN} state_t;

    // Operands and opcode captured at accept; the datapath only ever looks at this copy
    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } md_req_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    md_req_t        req, req_nxt;
    logic [31:0]    hi, lo, hi_nxt, lo_nxt;
    logic           busy;

    logic [63:0]        prod;
    logic signed [32:0] dvd, dvs, quo, rem;
    logic               unused_div_msb;

    assign busy        = (state == RUN);
    assign md.busy     = busy;
    assign md.md_stall = (md.start | busy) & md.id_md_use;
    assign md.hi       = hi;
    assign md.lo       = lo;

    // Result datapath from the latched request; 33-bit signed division makes
    // 0x80000000 / -1 land on quotient 0x80000000 with remainder 0 without overflow.
    always_comb begin
        prod = '0;
        if (req.op == OP_MULT) begin
            prod = $signed({{32{req.a[31]}}, req.a}) * $signed({{32{req.b[31]}}, req.b});
        end else begin
            prod = {32'b0, req.a} * {32'b0, req.b};
        end
        dvd = (req.op == OP_DIV) ? {req.a[31], req.a} : {1'b0, req.a};
        dvs = (req.op == OP_DIV) ? {req.b[31], req.b} : {1'b0, req.b};
        // Divide-by-zero results are discarded; keep the divider fed with a legal value
        if (req.b == 32'd0) begin
            dvs = 33'sd1;
        end
        quo = dvd / dvs;
        rem = dvd % dvs;
    end

    assign unused_div_msb = quo[32] ^ rem[32];

    // Next-state, counter, operand capture and HI/LO update decisions
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_nxt   = req;
        hi_nxt    = hi;
        lo_nxt    = lo;
        case (state)
            IDLE: begin
                if (md.start && !md.cancel && md.md_op <= OP_DIVU) begin
                    req_nxt   = '{op: md.md_op, a: md.a, b: md.b};
                    cnt_nxt   = (md.md_op == OP_MULT || md.md_op == OP_MULTU) ?
                                CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                    state_nxt = RUN;
                end else if (!md.cancel && md.md_op == OP_MTHI) begin
                    hi_nxt = md.a;
                end else if (!md.cancel && md.md_op == OP_MTLO) begin
                    lo_nxt = md.a;
                end
            end
            RUN: begin
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nxt = IDLE;
                    if (req.op == OP_MULT || req.op == OP_MULTU) begin
                        hi_nxt = prod[63:32];
                        lo_nxt = prod[31:0];
                    end else if (req.b != 32'd0) begin
                        hi_nxt = rem[31:0];
                        lo_nxt = quo[31:0];
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counter, latched request and architectural HI/LO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            req <= '0;
            hi  <= '0;
            lo  <= '0;
        end else begin
            cnt <= cnt_nxt;
            req <= req_nxt;
            hi  <= hi_nxt;
            lo  <= lo_nxt;
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// Purpose: randomized + directed scoreboard bench for mdu_ctrl against a plain-arithmetic model.
// Latency: expects HI/LO at issue cycle + 1 + N (N = 5 mult, 10 div, 0 for mthi/mtlo/no-ops).
// Backpressure: stimulus waits for busy to drop (bounded) before issuing the next operation.
module tb_mdu_ctrl;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_ctrl_if md();

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md)
    );

    typedef struct {
        int          due;
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference arithmetic straight from the instruction definitions
    function automatic void model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                  inout logic [31:0] h, inout logic [31:0] l);
        longint          p, sx, sy;
        longint unsigned up;
        case (op)
            3'd0: begin
                p = longint'($signed(x)) * longint'($signed(y));
                h = p[63:32];
                l = p[31:0];
            end
            3'd1: begin
                up = longint'({32'b0, x}) * longint'({32'b0, y});
                h  = up[63:32];
                l  = up[31:0];
            end
            3'd2: if (y != 0) begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
                p  = sx / sy;
                l  = p[31:0];
                p  = sx % sy;
                h  = p[31:0];
            end
            3'd3: if (y != 0) begin
                l = x / y;
                h = x % y;
            end
            default: ;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Guard: the bench must never issue into a busy unit
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(md.busy && (md.start || (!md.cancel && (md.md_op == 3'd4 || md.md_op == 3'd5)))))
                else $error("operation issued while busy");
        end
    end

    // Monitor: measures busy run length and retires scoreboard entries when due
    logic prev_busy = 1'b0;
    int   run_len   = 0;
    int   last_run  = 0;
    always @(negedge clk) begin
        exp_t e;
        if (md.busy === 1'b1) begin
            run_len++;
        end else begin
            if (prev_busy) last_run = run_len;
            run_len = 0;
        end
        prev_busy = (md.busy === 1'b1);
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due < cyc) begin
                n_cmp++;
                n_fail++;
                $display("FAIL late_result: due cycle %0d, now %0d", e.due, cyc);
            end else begin
                chk("hi", md.hi, e.hi);
                chk("lo", md.lo, e.lo);
                chk("busy_after", 32'(md.busy), 32'd0);
                if (e.n > 0) chk("busy_len", 32'(last_run), 32'(e.n));
            end
        end
    end

    task automatic wait_idle(input logic use_d);
        int guard = 0;
        while (md.busy !== 1'b0 && guard < 40) begin
            @(negedge clk);
            chk("stall_busy", 32'(md.md_stall), 32'(use_d));
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 40) begin
            n_cmp++;
            n_fail++;
            $display("FAIL busy_timeout: busy=%b, expected 0 within 40 cycles", md.busy);
        end
    endtask

    // Drive one E-stage operation for a cycle; entered and left at posedge+1
    task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic canc, input logic is_start, input logic use_d);
        exp_t e;
        int   n = 0;
        md.start     = is_start;
        md.md_op     = op;
        md.cancel    = canc;
        md.a         = x;
        md.b         = y;
        md.id_md_use = use_d;
        if (!canc) begin
            if (is_start && op <= 3'd3) begin
                model(op, x, y, exp_hi, exp_lo);
                n = (op <= 3'd1) ? MC : DC;
            end else if (op == 3'd4) begin
                exp_hi = x;
            end else if (op == 3'd5) begin
                exp_lo = x;
            end
        end
        e.due = cyc + 1 + n;
        e.hi  = exp_hi;
        e.lo  = exp_lo;
        e.n   = n;
        sb.push_back(e);
        @(negedge clk);
        chk("stall_start", 32'(md.md_stall), 32'(is_start & use_d));
        @(posedge clk);
        #1;
        md.start  = 1'b0;
        md.md_op  = 3'd6;
        md.cancel = 1'b0;
        md.a      = $urandom;
        md.b      = $urandom;
        wait_idle(use_d);
        md.id_md_use = 1'b0;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [2:0] op;
        reset        = 1'b1;
        md.start     = 1'b0;
        md.md_op     = 3'd6;
        md.cancel    = 1'b0;
        md.a         = '0;
        md.b         = '0;
        md.id_md_use = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(md.busy), 32'd0);
        chk("rst_hi", md.hi, 32'd0);
        chk("rst_lo", md.lo, 32'd0);
        chk("rst_stall", 32'(md.md_stall), 32'd0);
        @(posedge clk);
        #1 md.id_md_use = 1'b0;

        // Directed arithmetic cases
        issue(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b1, 1'b0);
        chk("t1_hi", exp_hi, 32'hFFFF_FFFF);
        chk("t1_lo", exp_lo, 32'hFFFF_FFF1);
        issue(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1, 1'b1);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 1'b0);
        issue(3'd3, 32'd7, 32'd2, 1'b0, 1'b1, 1'b0);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
        chk("ovf_lo", md.lo, 32'h8000_0000);
        chk("ovf_hi", md.hi, 32'h0000_0000);

        // Divide by zero keeps preloaded HI/LO
        issue(3'd4, 32'h11, 32'd0, 1'b0, 1'b0, 1'b0);
        issue(3'd5, 32'h22, 32'd0, 1'b0, 1'b0, 1'b0);
        issue(3'd2, 32'd5, 32'd0, 1'b0, 1'b1, 1'b0);
        chk("dz_hi", md.hi, 32'h11);
        chk("dz_lo", md.lo, 32'h22);

        // Cancelled start, then mtlo
        issue(3'd0, 32'd9, 32'd9, 1'b1, 1'b1, 1'b0);
        issue(3'd5, 32'hABCD, 32'd0, 1'b0, 1'b0, 1'b0);

        // Stall through a div, then asynchronous reset mid-run
        md.start     = 1'b1;
        md.md_op     = 3'd2;
        md.a         = 32'd100;
        md.b         = 32'd7;
        md.id_md_use = 1'b1;
        @(negedge clk);
        chk("t5_stall_start", 32'(md.md_stall), 32'd1);
        @(posedge clk);
        #1;
        md.start = 1'b0;
        md.md_op = 3'd6;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_stall_run", 32'(md.md_stall), 32'd1);
            chk("t5_busy_run", 32'(md.busy), 32'd1);
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        chk("t5_rst_busy", 32'(md.busy), 32'd0);
        chk("t5_rst_hi", md.hi, 32'd0);
        chk("t5_rst_lo", md.lo, 32'd0);
        #1 reset = 1'b0;
        sb.delete();
        exp_hi       = '0;
        exp_lo       = '0;
        md.id_md_use = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        issue(3'd6, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

        // Randomized mix
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 6));
            issue(op, pick_val(), pick_val(), ($urandom_range(0, 7) == 0),
                  (op <= 3'd3), 1'($urandom_range(0, 1)));
        end

        repeat (2) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
